// File: rtl/vga_rx_pkg.sv
// Shared VGA timing definitions: lock FSM states and 640x480@60 default timing.
// Also holds the saturating counter step used by the receive counters.
package vga_rx_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } lock_state_e;

   localparam int H_SYNC  = 96;
   localparam int H_BACK  = 48;
   localparam int H_ACT   = 640;
   localparam int H_FRONT = 16;
   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;

   localparam int V_SYNC  = 2;
   localparam int V_BACK  = 33;
   localparam int V_ACT   = 480;
   localparam int V_FRONT = 10;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;

   localparam int CNT_W = 11;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Registers a sync input and flags the cycle its sample enters the active level.
// Reset clears both samples to 0 so an active-low sync present at reset release is not an edge.
module vga_edge_det #(
   parameter bit POL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sync_i,
   output logic edge_o
);

   logic sample_q;
   logic prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sample_q <= 1'b0;
         prev_q   <= 1'b0;
      end else begin
         sample_q <= sync_i;
         prev_q   <= sample_q;
      end
   end

   assign edge_o = (sample_q == POL) && (prev_q != POL);

endmodule

// File: rtl/vga_sync_rx.sv
// VGA receiver: measures line/frame length, locks onto the timing and
// regenerates pixel coordinates, data-enable and frame-start for the active window.
module vga_sync_rx
   import vga_rx_pkg::*;
#(
   parameter bit SYNC_POL    = 1'b0,
   parameter int H_START     = H_SYNC + H_BACK,
   parameter int H_ACTIVE    = H_ACT,
   parameter int V_START     = V_SYNC + V_BACK,
   parameter int V_ACTIVE    = V_ACT,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        sclk,
   input  logic        rst_n,
   input  logic [3:0]  vga_r,
   input  logic [3:0]  vga_g,
   input  logic [3:0]  vga_b,
   input  logic        h_sync,
   input  logic        v_sync,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        pix_de,
   output logic [11:0] pix_data,
   output logic        frame_start,
   output logic        locked,
   output logic        lock_lost,
   output logic [10:0] h_total,
   output logic [10:0] v_total
);

   localparam logic [CNT_W-1:0] H_LO   = CNT_W'(H_START);
   localparam logic [CNT_W-1:0] H_HI   = CNT_W'(H_START + H_ACTIVE);
   localparam logic [CNT_W-1:0] V_LO   = CNT_W'(V_START);
   localparam logic [CNT_W-1:0] V_HI   = CNT_W'(V_START + V_ACTIVE);
   localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

   logic             h_edge, v_edge;
   logic [11:0]      rgb_p0_q;
   lock_state_e      state_q, state_d;
   logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [CNT_W-1:0] h_inc, v_inc;
   logic [CNT_W-1:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
   logic [CNT_W-1:0] h_ref_q, h_ref_d, v_ref_q, v_ref_d;
   logic [3:0]       match_q, match_d, match_inc;
   logic             meas_ok, lost;
   logic             de_d, fs_d, lost_d;
   logic [9:0]       pix_x_d, pix_y_d, pix_x_q, pix_y_q;
   logic [11:0]      pix_data_d, pix_data_q;
   logic             pix_de_q, fs_q, locked_q, lost_q;

   // Stage 0: sync samples live inside the edge detectors, colour alongside them
   vga_edge_det #(.POL(SYNC_POL)) u_h_edge (
      .clk_i  (sclk),
      .rst_ni (rst_n),
      .sync_i (h_sync),
      .edge_o (h_edge)
   );

   vga_edge_det #(.POL(SYNC_POL)) u_v_edge (
      .clk_i  (sclk),
      .rst_ni (rst_n),
      .sync_i (v_sync),
      .edge_o (v_edge)
   );

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) rgb_p0_q <= '0;
      else        rgb_p0_q <= {vga_r, vga_g, vga_b};
   end

   // Stage 1: counters and measurements; a v edge wins over a coincident h edge
   always_comb begin
      h_inc    = sat_inc(h_cnt_q);
      v_inc    = sat_inc(v_cnt_q);
      h_cnt_d  = h_edge ? '0 : h_inc;
      v_cnt_d  = v_cnt_q;
      if (v_edge)      v_cnt_d = '0;
      else if (h_edge) v_cnt_d = v_inc;
      h_meas_d = h_edge ? h_inc : h_meas_q;
      v_meas_d = v_edge ? v_inc : v_meas_q;
   end

   always_comb begin
      state_d   = state_q;
      h_ref_d   = h_ref_q;
      v_ref_d   = v_ref_q;
      match_d   = match_q;
      match_inc = match_q + 4'd1;
      meas_ok   = (h_meas_d == h_ref_q) && (v_inc == v_ref_q);
      lost      = (h_edge && (h_inc != h_ref_q)) ||
                  (v_edge && (v_inc != v_ref_q)) ||
                  (h_cnt_q == CNT_MAX);
      unique case (state_q)
         SEARCH: begin
            if (v_edge) begin
               state_d = MEASURE;
               h_ref_d = h_meas_d;
               v_ref_d = v_inc;
               match_d = '0;
            end
         end
         MEASURE: begin
            if (v_edge) begin
               if (meas_ok) begin
                  match_d = match_inc;
                  if (match_inc == LOCK_N) state_d = LOCKED;
               end else begin
                  h_ref_d = h_meas_d;
                  v_ref_d = v_inc;
                  match_d = '0;
               end
            end
         end
         LOCKED: begin
            if (lost) state_d = SEARCH;
         end
         default: state_d = SEARCH;
      endcase
   end

   // Outputs are formed from next-state counters so they register with the same sample
   always_comb begin
      de_d       = (state_d == LOCKED) &&
                   (h_cnt_d >= H_LO) && (h_cnt_d < H_HI) &&
                   (v_cnt_d >= V_LO) && (v_cnt_d < V_HI);
      pix_x_d    = de_d ? 10'(h_cnt_d - H_LO) : '0;
      pix_y_d    = de_d ? 10'(v_cnt_d - V_LO) : '0;
      pix_data_d = de_d ? rgb_p0_q : '0;
      fs_d       = de_d && (pix_x_d == '0) && (pix_y_d == '0);
      lost_d     = (state_q == LOCKED) && (state_d == SEARCH);
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SEARCH;
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         h_meas_q   <= '0;
         v_meas_q   <= '0;
         h_ref_q    <= '0;
         v_ref_q    <= '0;
         match_q    <= '0;
         pix_x_q    <= '0;
         pix_y_q    <= '0;
         pix_data_q <= '0;
         pix_de_q   <= 1'b0;
         fs_q       <= 1'b0;
         locked_q   <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         h_meas_q   <= h_meas_d;
         v_meas_q   <= v_meas_d;
         h_ref_q    <= h_ref_d;
         v_ref_q    <= v_ref_d;
         match_q    <= match_d;
         pix_x_q    <= pix_x_d;
         pix_y_q    <= pix_y_d;
         pix_data_q <= pix_data_d;
         pix_de_q   <= de_d;
         fs_q       <= fs_d;
         locked_q   <= (state_d == LOCKED);
         lost_q     <= lost_d;
      end
   end

   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_data    = pix_data_q;
   assign pix_de      = pix_de_q;
   assign frame_start = fs_q;
   assign locked      = locked_q;
   assign lock_lost   = lost_q;
   assign h_total     = h_meas_q;
   assign v_total     = v_meas_q;

endmodule
